// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
//   Sequencing controller for the HI/LO register in the execute stage.
//   Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO. Runs a MUL_LAT-cycle multiply or a
//   32-iteration restoring divider, holds the front of the pipeline while busy,
//   and drives the HI/LO write port.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   op_valid     E stage holds a HI/LO-writing instruction (held while stalled)
//   op[2:0]      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   src_a[31:0]  rs operand (dividend / multiplicand / MT source)
//   src_b[31:0]  rt operand (divisor / multiplier)
//   flush        cancel the E-stage instruction; overrides everything
//   stall_o      freeze F/D/E stages
//   hilo_we      HI/LO write enable
//   hilo_select  00 write both, 11 HI only, 10 LO only
//   hilo_wdata   {HI,LO} write data
//   div_zero     one-cycle pulse when a divide by zero completes
// -----------------------------------------------------------------------------
module muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall_o,
  output logic        hilo_we,
  output logic [1:0]  hilo_select,
  output logic [63:0] hilo_wdata,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Counter must hold both MUL_LAT-1 and the 31 divide iterations.
  localparam int CNT_W = (MUL_LAT > 32) ? $clog2(MUL_LAT) : 5;
  localparam logic [CNT_W-1:0] CNT_MUL  = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(31);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      a_r;        // multiplicand
  logic [31:0]      b_r;        // multiplier or divisor magnitude
  logic [31:0]      rem_r;      // partial remainder
  logic [31:0]      quo_r;      // dividend magnitude shifting out, quotient shifting in
  logic             signed_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             zero_r;
  logic [63:0]      result_r;

  // Decode of the instruction presented in IDLE.
  logic        is_muldiv_s, is_mul_s, is_signed_s, accept_s, cnt_done_s;
  logic [31:0] a_mag_s, b_mag_s;

  assign is_muldiv_s = (op[2] == 1'b0);
  assign is_mul_s    = (op[2:1] == 2'b00);
  assign is_signed_s = (op[0] == 1'b0);
  assign accept_s    = (state_r == S_IDLE) && op_valid && !flush && is_muldiv_s;
  assign cnt_done_s  = (cnt_r == CNT_ZERO);
  assign a_mag_s     = (is_signed_s && src_a[31]) ? (32'd0 - src_a) : src_a;
  assign b_mag_s     = (is_signed_s && src_b[31]) ? (32'd0 - src_b) : src_b;

  // One restoring division step: shift in the next dividend bit, trial subtract.
  logic [32:0] rem_sh_s;
  logic [33:0] sub_s;
  logic        q_bit_s;
  logic [31:0] rem_step_s, quo_step_s, rem_fix_s, quo_fix_s;

  assign rem_sh_s   = {rem_r, quo_r[31]};
  assign sub_s      = {1'b0, rem_sh_s} - {2'b00, b_r};
  assign q_bit_s    = ~sub_s[33];
  assign rem_step_s = q_bit_s ? sub_s[31:0] : rem_sh_s[31:0];
  assign quo_step_s = {quo_r[30:0], q_bit_s};
  // Sign fix-up on the final step; the quotient of 0x80000000/-1 wraps to itself.
  assign quo_fix_s  = neg_q_r ? (32'd0 - quo_step_s) : quo_step_s;
  assign rem_fix_s  = neg_r_r ? (32'd0 - rem_step_s) : rem_step_s;

  // 64x64 multiply of the extended operands; the low half is the exact product.
  logic [63:0] prod_s;
  assign prod_s = {{32{signed_r & a_r[31]}}, a_r} * {{32{signed_r & b_r[31]}}, b_r};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand latching, iteration counter and result datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= CNT_ZERO;
      a_r      <= 32'd0;
      b_r      <= 32'd0;
      rem_r    <= 32'd0;
      quo_r    <= 32'd0;
      signed_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      zero_r   <= 1'b0;
      result_r <= 64'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            signed_r <= is_signed_s;
            neg_q_r  <= is_signed_s && (src_a[31] ^ src_b[31]);
            neg_r_r  <= is_signed_s && src_a[31];
            zero_r   <= !is_mul_s && (src_b == 32'd0);
            a_r      <= src_a;
            rem_r    <= 32'd0;
            if (is_mul_s) begin
              b_r   <= src_b;
              quo_r <= 32'd0;
              cnt_r <= CNT_MUL;
            end else begin
              b_r   <= b_mag_s;
              quo_r <= a_mag_s;
              cnt_r <= (src_b == 32'd0) ? CNT_ZERO : CNT_DIV;
            end
          end
        end
        S_MUL: begin
          if (cnt_done_s) begin
            result_r <= prod_s;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_DIV: begin
          rem_r <= rem_step_s;
          quo_r <= quo_step_s;
          if (cnt_done_s) begin
            result_r <= {rem_fix_s, quo_fix_s};
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Next-state logic; flush returns to IDLE from anywhere.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            if (is_mul_s) begin
              state_nxt_s = S_MUL;
            end else if (src_b == 32'd0) begin
              state_nxt_s = S_DONE;
            end else begin
              state_nxt_s = S_DIV;
            end
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_MUL, S_DIV: begin
          if (cnt_done_s) begin
            state_nxt_s = S_DONE;
          end else begin
            state_nxt_s = state_r;
          end
        end
        S_DONE:  state_nxt_s = S_IDLE;
        default: state_nxt_s = S_IDLE;
      endcase
    end
  end

  // Output decode: stall while accepting/busy, MT writes in IDLE, result write in DONE.
  always_comb begin
    stall_o     = 1'b0;
    hilo_we     = 1'b0;
    hilo_select = 2'b00;
    hilo_wdata  = 64'd0;
    div_zero    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          stall_o = 1'b1;
        end else if (op_valid && !flush && (op == 3'b100)) begin
          hilo_we     = 1'b1;
          hilo_select = 2'b11;
          hilo_wdata  = {src_a, 32'd0};
        end else if (op_valid && !flush && (op == 3'b101)) begin
          hilo_we     = 1'b1;
          hilo_select = 2'b10;
          hilo_wdata  = {32'd0, src_a};
        end else begin
          stall_o = 1'b0;
        end
      end
      S_MUL, S_DIV: begin
        stall_o = !flush;
      end
      S_DONE: begin
        if (flush) begin
          hilo_we = 1'b0;
        end else if (zero_r) begin
          div_zero = 1'b1;
        end else begin
          hilo_we    = 1'b1;
          hilo_wdata = result_r;
        end
      end
      default: begin
        stall_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
//   Scoreboard bench for muldiv_ctrl. The driver pushes the expected HI/LO
//   write (computed with plain integer arithmetic) when it issues an op; a
//   monitor on the falling edge pops and compares on every write or div_zero.
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        flush = 1'b0;
  logic        stall_o, hilo_we, div_zero;
  logic [1:0]  hilo_select;
  logic [63:0] hilo_wdata;

  muldiv_ctrl #(.MUL_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .src_a(src_a),
    .src_b(src_b), .flush(flush), .stall_o(stall_o), .hilo_we(hilo_we),
    .hilo_select(hilo_select), .hilo_wdata(hilo_wdata), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [63:0] data;
    bit          zero;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // Reference model: HI/LO result of one instruction and its stall count.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output exp_t e, output int stalls);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    e.sel = 2'b00; e.data = 64'd0; e.zero = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    stalls = 0;
    case (o)
      3'd0: begin e.data = 64'(sa * sb); stalls = LAT + 1; end
      3'd1: begin e.data = ua * ub;      stalls = LAT + 1; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          e.zero = 1'b1; stalls = 1;
        end else begin
          stalls = 33;
          if (o == 3'd2) begin
            q = sa / sb; r = sa % sb;
            e.data = {r[31:0], q[31:0]};
          end else begin
            uq = ua / ub; ur = ua % ub;
            e.data = {ur[31:0], uq[31:0]};
          end
        end
      end
      3'd4: begin e.sel = 2'b11; e.data = {a, 32'd0}; end
      default: begin e.sel = 2'b10; e.data = {32'd0, a}; end
    endcase
  endtask

  // Issue one op (called just after a rising edge) and hold it until the stall drops.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   exp_stalls, stalls;
    bit   done;
    model(o, a, b, e, exp_stalls);
    exp_q.push_back(e);
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    stalls = 0; done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (stall_o) stalls++;
      else done = 1'b1;
      @(posedge clk); #1;
    end
    op_valid = 1'b0; op = 3'd7; src_a = $urandom; src_b = $urandom;
    if (!done) begin
      checks++; errors++;
      $display("FAIL op_timeout actual=stalled expected=complete op=%0d", o);
    end
    check("stall_cycles", 64'(stalls), 64'(exp_stalls));
  endtask

  // Monitor: every write or div_zero pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (hilo_we || div_zero) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write actual=we%0d/dz%0d sel=%b data=%h expected=none",
                 hilo_we, div_zero, hilo_select, hilo_wdata);
      end else begin
        e = exp_q.pop_front();
        check("div_zero", 64'(div_zero), 64'(e.zero));
        check("hilo_we", 64'(hilo_we), 64'(!e.zero));
        if (!e.zero) begin
          check("hilo_select", 64'(hilo_select), 64'(e.sel));
          check("hilo_wdata", hilo_wdata, e.data);
        end
      end
    end
  end

  task automatic check_quiet(input string tag);
    @(negedge clk);
    check({tag, "_stall"}, 64'(stall_o), 64'd0);
    check({tag, "_we"}, 64'(hilo_we), 64'd0);
    check({tag, "_sel"}, 64'(hilo_select), 64'd0);
    check({tag, "_wdata"}, hilo_wdata, 64'd0);
    check({tag, "_dz"}, 64'(div_zero), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_quiet("reset");

    // Directed cases
    run_op(3'd0, 32'hFFFFFFFF, 32'd2);
    run_op(3'd1, 32'hFFFFFFFF, 32'd2);
    run_op(3'd3, 32'd100, 32'd7);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
    run_op(3'd2, 32'd55, 32'd0);
    run_op(3'd3, 32'hDEADBEEF, 32'd0);
    run_op(3'd4, 32'h12345678, 32'd0);
    run_op(3'd5, 32'h12345678, 32'd0);
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);

    // DIVU flushed on its tenth iteration: no write, idle next cycle
    op_valid = 1'b1; op = 3'd3; src_a = 32'd1000; src_b = 32'd3;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; op_valid = 1'b0;
    check_quiet("flush_div");
    repeat (40) @(posedge clk);
    #1;

    // Flush during the DONE cycle of a multiply
    op_valid = 1'b1; op = 3'd0; src_a = 32'd9; src_b = 32'd9;
    repeat (LAT + 1) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush_done_we", 64'(hilo_we), 64'd0);
    @(posedge clk); #1 flush = 1'b0; op_valid = 1'b0;

    // Flush during DONE of a divide by zero suppresses div_zero
    op_valid = 1'b1; op = 3'd2; src_a = 32'd9; src_b = 32'd0;
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    check("flush_done_dz", 64'(div_zero), 64'd0);
    @(posedge clk); #1 flush = 1'b0; op_valid = 1'b0;

    // Flush alongside MTHI in IDLE: no write
    op_valid = 1'b1; op = 3'd4; src_a = 32'hCAFEF00D; flush = 1'b1;
    @(negedge clk);
    check("flush_mthi_we", 64'(hilo_we), 64'd0);
    @(posedge clk); #1 flush = 1'b0; op_valid = 1'b0;

    // Reset in the middle of a multiply
    op_valid = 1'b1; op = 3'd0; src_a = 32'd7; src_b = 32'd6;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; op_valid = 1'b0;
    check_quiet("reset_mid_mul");
    repeat (5) @(posedge clk);
    #1;

    // Back-to-back MULT then MTLO
    run_op(3'd0, 32'h00010000, 32'h00010000);
    run_op(3'd5, 32'hA5A5A5A5, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(0, 5));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'd0;
      if ($urandom_range(0, 7) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000000F;
      run_op(ro, ra, rb);
    end

    repeat (4) @(posedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencing controller for the HI/LO register in the execute (E) stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, runs a MUL_LAT-cycle multiply and a 32-iteration restoring divider, stalls the pipeline while busy, and drives the HI/LO write port (we, 2-bit select, 64-bit data).
- Sits between E-stage decode/operand forwarding and the HI/LO register; the HI/LO read path is untouched.

Parameters:
- MUL_LAT, 2, cycles spent in MUL state (≥1); the product is registered at the end of the last cycle.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- op_valid  input  1  E-stage holds a HI/LO-writing instruction; held stable by pipeline while stall_o=1
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others ignored
- src_a  input  32  rs operand (dividend / multiplicand / MT source)
- src_b  input  32  rt operand (divisor / multiplier)
- flush  input  1  cancel E-stage instruction (exception/eret)
- stall_o  output  1  freeze F/D/E stages
- hilo_we  output  1  HI/LO write enable
- hilo_select  output  2  00 write both, 11 HI only, 10 LO only
- hilo_wdata  output  64  {HI,LO} write data
- div_zero  output  1  one-cycle pulse: division with divisor 0 completed

Behaviour:
- States: IDLE, MUL, DIV, DONE.
- Reset: state=IDLE, counter=0, operand/result regs=0, div_zero=0. With op_valid=0, stall_o=0 and hilo_we=0. Reset mid-operation aborts with no HI/LO write.
- Flush has priority over everything:
  - In any state, flush → IDLE next cycle with no write.
  - In IDLE, flush with op_valid → not accepted, no MT write.
  - In DONE, flush forces hilo_we=0 and suppresses div_zero.
- IDLE:
  - op_valid & MUL/DIV op & ~flush → latch operands and signedness; stall_o=1 (Mealy) this cycle.
  - MUL ops → MUL with cnt=MUL_LAT-1.
  - DIV ops with src_b≠0 → DIV with cnt=31.
  - DIV ops with src_b=0 → DONE with zero flag set.
- IDLE, MTHI/MTLO (Mealy, same cycle, no stall, state stays IDLE):
  - hilo_we=1.
  - MTHI: select=11, wdata={src_a,32'b0}.
  - MTLO: select=10, wdata={32'b0,src_a}.
- MUL:
  - stall_o=1; cnt decrements each cycle.
  - At cnt=0: register the 64-bit product and go to DONE.
  - MULT is signed 32x32; MULTU is unsigned.
- DIV:
  - stall_o=1; one restoring step per cycle on magnitudes (|a|,|b| for DIV, raw for DIVU).
  - After cnt=0 step → DONE.
  - Sign fix-up applied on entry to DONE: quotient negated iff operand signs differ; remainder takes dividend sign.
  - 0x80000000 / 0xFFFFFFFF (signed) → Q=0x80000000, R=0.
- DONE:
  - stall_o=0; hilo_we=1; select=00; wdata={HI,LO}. For mul, {HI,LO}=product; for div, HI=remainder, LO=quotient.
  - HI/LO therefore update on the same edge the instruction leaves E.
  - Divisor zero: hilo_we=0 (HI/LO unchanged) and div_zero=1.
  - Next state IDLE unconditionally; op_valid in DONE is never re-accepted.
- Latency (accept cycle to DONE cycle inclusive):
  - MUL: MUL_LAT+2 cycles in E, MUL_LAT+1 stall cycles.
  - DIV: 34 cycles in E, 33 stall cycles.
  - DIV by zero: 2 cycles in E, 1 stall cycle.
- Outside DONE and the IDLE MT case: hilo_we=0, hilo_select=00, hilo_wdata=0.
- op_valid or op changes in MUL/DIV are ignored; latched copies are used.

Test Plan:
- MULT src_a=0xFFFFFFFF, src_b=2, MUL_LAT=2 → stall_o high exactly 3 cycles; DONE cycle hilo_we=1, select=00, wdata=0xFFFFFFFF_FFFFFFFE. MULTU with the same operands → 0x00000001_FFFFFFFE.
- DIVU 100/7 → stall_o high 33 cycles; DONE wdata={0x00000002,0x0000000E}. DIV −7/2 → HI=0xFFFFFFFF, LO=0xFFFFFFFD. DIV 0x80000000/−1 → LO=0x80000000, HI=0.
- DIV src_b=0 → 1 stall cycle, then DONE with hilo_we=0 and div_zero=1 for one cycle.
- MTHI src_a=0x12345678 in IDLE → same-cycle hilo_we=1, select=11, wdata[63:32]=0x12345678, stall_o=0. MTLO → select=10.
- DIVU started, flush on iteration 10 → IDLE next cycle, stall_o=0, no hilo_we pulse. Flush asserted in DONE → hilo_we=0. Flush with op_valid MTHI → no write.
- Reset asserted mid-MUL → IDLE, all outputs 0. Back-to-back MULT then MTLO → MTLO write occurs the cycle after DONE, never in DONE.
